// File: rtl/conv_pkg.sv
// Shared types and geometry defaults for the convolution sequencer.
// Holds the FSM state enum and the window-count helper.
package conv_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      DONE
   } state_t;

   localparam int IMG_W_D    = 10;
   localparam int IMG_H_D    = 10;
   localparam int K_D        = 3;
   localparam int DW_N_D     = 21;
   localparam int KER_N_D    = 24;
   localparam int PIPE_LAT_D = 4;

   // Number of valid KxK window positions in a w x h image.
   function automatic int n_win(input int w, input int h, input int k);
      return (h - k + 1) * (w - k + 1);
   endfunction

endpackage

// File: rtl/conv_seq_ctrl_if.sv
// Control/status bundle between the stream source and the sequencer.
// master = stream source side, slave = sequencer side.
interface conv_seq_ctrl_if;

   logic       IN_VALID;
   logic       KERNEL_VALID;
   logic       coef_we;
   logic [4:0] coef_addr;
   logic       lb_shift;
   logic       win_valid;
   logic [3:0] row_idx;
   logic [3:0] col_idx;
   logic       OUT_VALID;
   logic [6:0] out_cnt;
   logic       busy;
   logic       done;
   logic       err_order;
   logic       err_proto;
   logic       err_wdog;

   modport master (
      output IN_VALID, KERNEL_VALID,
      input  coef_we, coef_addr, lb_shift,
      input  win_valid, row_idx, col_idx,
      input  OUT_VALID, out_cnt, busy, done,
      input  err_order, err_proto, err_wdog
   );

   modport slave (
      input  IN_VALID, KERNEL_VALID,
      output coef_we, coef_addr, lb_shift,
      output win_valid, row_idx, col_idx,
      output OUT_VALID, out_cnt, busy, done,
      output err_order, err_proto, err_wdog
   );

endinterface

// File: rtl/conv_valid_pipe.sv
// Tracks window strobes through the MAC pipeline.
// Tail bit is the result-valid; empty flags no pending results.
module conv_valid_pipe #(
   parameter int LAT = 4
) (
   input  logic CLK,
   input  logic RESET,
   input  logic din,
   output logic dout,
   output logic empty
);

   logic [LAT-1:0] sr;

   // Shift every cycle, regardless of pixel gaps.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) sr <= '0;
      else       sr <= (sr << 1) | LAT'(din);
   end

   assign dout  = sr[LAT-1];
   assign empty = ~|sr;

endmodule

// File: rtl/conv_seq_ctrl.sv
// Convolution sequencer: coefficient load, pixel row/col, window issue.
// Optional output-gap watchdog enabled by defining CONV_WDOG_EN.
module conv_seq_ctrl
   import conv_pkg::*;
#(
   parameter int IMG_W    = IMG_W_D,
   parameter int IMG_H    = IMG_H_D,
   parameter int K        = K_D,
   parameter int DW_N     = DW_N_D,
   parameter int KER_N    = KER_N_D,
   parameter int PIPE_LAT = PIPE_LAT_D
`ifdef CONV_WDOG_EN
   ,
   parameter int WDOG_MAX = 15
`endif
) (
   input logic           CLK,
   input logic           RESET,
   conv_seq_ctrl_if.slave bus
);

   localparam int KW   = $clog2(KER_N + 1);
   localparam int NWIN = n_win(IMG_W, IMG_H, K);
   localparam int OW   = $clog2(NWIN + 1);

   if (IMG_W > 16 || IMG_H > 16) begin : g_geom_chk
      $error("row/col ports are 4 bits wide");
   end

   if (PIPE_LAT < 1) begin : g_lat_chk
      $error("PIPE_LAT must be at least 1");
   end

   state_t        state;
   logic [KW-1:0] kcnt;
   logic [KW-1:0] kcnt_nxt;
   logic [3:0]    row;
   logic [3:0]    col;
   logic [OW-1:0] ocnt;
   logic          busy_q;
   logic          done_q;
   logic          e_order;
   logic          e_proto;
   logic          wdog;
   logic          px_ok;
   logic          px_acc;
   logic          k_acc;
   logic          k_ovf;
   logic          last_px;
   logic          win;
   logic          start;
   logic          pipe_out;
   logic          pipe_empty;

   // Accept/strobe decode; gated by RESET so outputs drop at once.
   always_comb begin
      px_ok    = (state == IDLE) || (state == RUN);
      px_acc   = bus.IN_VALID & px_ok & ~RESET;
      k_acc    = bus.KERNEL_VALID & (kcnt < KW'(KER_N)) & ~RESET;
      k_ovf    = bus.KERNEL_VALID & (kcnt >= KW'(KER_N));
      kcnt_nxt = kcnt + KW'(k_acc);
      last_px  = px_acc & (row == 4'(IMG_H - 1))
                        & (col == 4'(IMG_W - 1));
      win      = px_acc & (row >= 4'(K - 1))
                        & (col >= 4'(K - 1));
      start    = bus.IN_VALID | bus.KERNEL_VALID;
   end

   // Coefficient index; survives frames, cleared only by reset.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) kcnt <= '0;
      else       kcnt <= kcnt_nxt;
   end

   // Pixel raster position; wraps to 0,0 after the last pixel.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         row <= '0;
         col <= '0;
      end else if (px_acc) begin
         if (col == 4'(IMG_W - 1)) begin
            col <= '0;
            if (row == 4'(IMG_H - 1)) row <= '0;
            else                      row <= row + 4'd1;
         end else begin
            col <= col + 4'd1;
         end
      end
   end

   // Frame FSM with registered busy/done.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state  <= IDLE;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         unique case (state)
            IDLE: if (start) begin
               state  <= last_px ? DRAIN : RUN;
               busy_q <= 1'b1;
            end
            RUN: if (last_px) state <= DRAIN;
            DRAIN: if (pipe_empty) begin
               state  <= DONE;
               busy_q <= 1'b0;
               done_q <= 1'b1;
            end
            DONE: begin
               state  <= IDLE;
               done_q <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Results delivered; restarts when a new frame begins.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET)                      ocnt <= '0;
      else if (state == IDLE && start) ocnt <= '0;
      else if (pipe_out)              ocnt <= ocnt + OW'(1);
   end

   // Sticky protocol and ordering errors.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         e_order <= 1'b0;
         e_proto <= 1'b0;
      end else begin
         if (win && kcnt_nxt < KW'(DW_N)) e_order <= 1'b1;
         if (k_ovf || (bus.IN_VALID && !px_ok)) e_proto <= 1'b1;
      end
   end

   conv_valid_pipe #(.LAT(PIPE_LAT)) u_pipe (
      .CLK   (CLK),
      .RESET (RESET),
      .din   (win),
      .dout  (pipe_out),
      .empty (pipe_empty)
   );

`ifdef CONV_WDOG_EN
   localparam int WW = $clog2(WDOG_MAX + 1);
   logic [WW-1:0] gap;
   logic          gap_on;

   assign gap_on = (state == RUN || state == DRAIN) && (ocnt != '0);

   // Cycles since last result once the first has appeared.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         gap  <= '0;
         wdog <= 1'b0;
      end else begin
         if (pipe_out || state == IDLE)
            gap <= '0;
         else if (gap_on && gap != WW'(WDOG_MAX))
            gap <= gap + WW'(1);
         if (gap_on && !pipe_out && gap == WW'(WDOG_MAX - 1))
            wdog <= 1'b1;
      end
   end
`else
   assign wdog = 1'b0;
`endif

   assign bus.coef_we   = k_acc;
   assign bus.coef_addr = 5'(kcnt);
   assign bus.lb_shift  = px_acc;
   assign bus.win_valid = win;
   assign bus.row_idx   = RESET ? 4'd0 : row;
   assign bus.col_idx   = RESET ? 4'd0 : col;
   assign bus.OUT_VALID = pipe_out;
   assign bus.out_cnt   = 7'(ocnt);
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.err_order = e_order;
   assign bus.err_proto = e_proto;
   assign bus.err_wdog  = wdog;

endmodule
